// File: rtl/alu12_pkg.sv
// alu12_pkg: shared definitions for the 12-bit ALU pipeline stages.
//   ALU_W       default data width
//   OP_*        operation-tag encodings (SUB occupies 100..111)
//   FLAG_*      bit positions of {Z,N,C,V} in a 4-bit flag word
//   flags_t     packed flag struct, same bit order as FLAG_*
package alu12_pkg;

    localparam int ALU_W = 12;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_SUB_LO = 3'b100;
    localparam logic [2:0] OP_SUB_HI = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Every tag with the top bit set is a subtract.
    function automatic logic is_sub(input logic [2:0] sel);
        return sel[2];
    endfunction

endpackage

// File: rtl/alu12_result_stage_if.sv
// alu12_result_stage_if: ALU-side and consumer-side bus of the result stage.
//   in_valid/in_ready, sel, a, b, o, carry   ALU result capture handshake
//   out_valid/out_ready, result, flags       head-of-buffer delivery handshake
//   sticky_v/clr_sticky, res_cnt             status and its clear
// master: ALU + consumer side; slave: the result stage.
interface alu12_result_stage_if
    import alu12_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W:0]       o;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    flags_t           flags;
    logic             sticky_v;
    logic             clr_sticky;
    logic [CNT_W-1:0] res_cnt;

    modport master (
        output in_valid, sel, a, b, o, carry, out_ready, clr_sticky,
        input  in_ready, out_valid, result, flags, sticky_v, res_cnt
    );

    modport slave (
        input  in_valid, sel, a, b, o, carry, out_ready, clr_sticky,
        output in_ready, out_valid, result, flags, sticky_v, res_cnt
    );

endinterface

// File: rtl/alu12_flag_gen.sv
// alu12_flag_gen: combinational Z/N/C/V derivation from an ALU operation.
//   i_sel    operation tag
//   i_a/i_b  operands as fed to the ALU (sign bits feed V)
//   i_o      ALU result bus; the top bit is always 0 and ignored
//   i_carry  carry (ADD) / borrow (SUB)
//   o_flags  {z,n,c,v}
module alu12_flag_gen
    import alu12_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [2:0]   i_sel,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W:0]   i_o,
    input  logic         i_carry,
    output flags_t       o_flags
);

    logic w_is_add;
    logic w_is_sub;
    logic w_sa, w_sb, w_so;
    logic w_unused_o_msb;

    assign w_unused_o_msb = i_o[W];

    assign w_is_add = (i_sel == OP_ADD);
    assign w_is_sub = is_sub(i_sel);
    assign w_sa     = i_a[W-1];
    assign w_sb     = i_b[W-1];
    assign w_so     = i_o[W-1];

    always_comb begin
        o_flags   = '0;
        o_flags.z = (i_o[W-1:0] == '0);
        o_flags.n = w_so;
        o_flags.c = (w_is_add | w_is_sub) & i_carry;
        // Signed overflow: result sign disagrees with A when the effective
        // operand signs agree (B's sign is inverted for subtraction).
        if (w_is_add)
            o_flags.v = (w_sa == w_sb) & (w_so != w_sa);
        else if (w_is_sub)
            o_flags.v = (w_sa != w_sb) & (w_so != w_sa);
    end

endmodule

// File: rtl/alu12_result_stage.sv
// alu12_result_stage: registered result stage behind the 12-bit ALU.
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset
//   bus    alu12_result_stage_if.slave (capture, delivery, status)
// Two-entry skid buffer (head + tail); head drives result/flags directly.
// in_ready depends only on registered occupancy and reset.
module alu12_result_stage
    import alu12_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu12_result_stage_if.slave  bus
);

    typedef struct packed {
        logic [W-1:0] res;
        flags_t       flags;
    } entry_t;

    logic [1:0]       r_occ;
    logic             r_vld;
    entry_t           r_head;
    entry_t           r_tail;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0] w_occ_nxt;
    entry_t     w_head_nxt;
    entry_t     w_tail_nxt;
    entry_t     w_new;
    flags_t     w_flags;
    logic       w_push;
    logic       w_pop;

    alu12_flag_gen #(.W(W)) u_flag_gen (
        .i_sel   (bus.sel),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .i_o     (bus.o),
        .i_carry (bus.carry),
        .o_flags (w_flags)
    );

    assign w_new.res   = bus.o[W-1:0];
    assign w_new.flags = w_flags;

    assign bus.in_ready = (r_occ < 2'd2) & ~i_rst;
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = r_vld & bus.out_ready;

    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_occ)
            2'd0: if (w_push) begin
                w_head_nxt = w_new;
                w_occ_nxt  = 2'd1;
            end
            2'd1: begin
                // Head is replaced on push+pop; head is left holding its
                // last value on a pop that empties the buffer.
                if (w_push && w_pop) begin
                    w_head_nxt = w_new;
                end else if (w_push) begin
                    w_tail_nxt = w_new;
                    w_occ_nxt  = 2'd2;
                end else if (w_pop) begin
                    w_occ_nxt  = 2'd0;
                end
            end
            2'd2: if (w_pop) begin
                w_head_nxt = r_tail;
                w_occ_nxt  = 2'd1;
            end
            default: w_occ_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ    <= '0;
            r_vld    <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_vld  <= (w_occ_nxt != 2'd0);
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            if (w_push && w_new.flags.v)
                r_sticky <= 1'b1;
            else if (bus.clr_sticky)
                r_sticky <= 1'b0;
            r_cnt <= r_cnt + CNT_W'(w_pop);
        end
    end

    assign bus.out_valid = r_vld;
    assign bus.result    = r_head.res;
    assign bus.flags     = r_head.flags;
    assign bus.sticky_v  = r_sticky;
    assign bus.res_cnt   = r_cnt;

endmodule

// File: tb/tb_alu12_result_stage.sv
// tb_alu12_result_stage: directed-vector bench for alu12_result_stage.
// Inputs change 1 time unit after a rising edge; outputs are checked there
// (or one unit later for the combinational in_ready).
module tb_alu12_result_stage;

    localparam int W     = 12;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   errs;
    int   nchk;

    alu12_result_stage_if #(.W(W), .CNT_W(CNT_W)) bus ();

    alu12_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] o, input logic c);
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.a        = a;
        bus.b        = b;
        bus.o        = {1'b0, o};
        bus.carry    = c;
    endtask

    initial begin
        errs = 0;
        nchk = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.sel        = '0;
        bus.a          = '0;
        bus.b          = '0;
        bus.o          = '0;
        bus.carry      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_result", 32'(bus.result), 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_sticky", 32'(bus.sticky_v), 32'h0);
        chk("rst_cnt", 32'(bus.res_cnt), 32'h0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(bus.in_ready), 32'h1);

        // ADD overflow 0x7FF + 1
        drive(3'b011, 12'h7FF, 12'h001, 12'h800, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'h1);
        chk("add_result", 32'(bus.result), 32'h800);
        chk("add_flags", 32'(bus.flags), 32'b0101);
        chk("add_sticky", 32'(bus.sticky_v), 32'h1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("add_pop_cnt", 32'(bus.res_cnt), 32'd1);
        chk("add_pop_empty", 32'(bus.out_valid), 32'h0);
        chk("hold_result", 32'(bus.result), 32'h800);

        // SUB 0 - 1, both SUB encodings
        drive(3'b100, 12'h000, 12'h001, 12'hFFF, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("sub100_flags", 32'(bus.flags), 32'b0110);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        drive(3'b111, 12'h000, 12'h001, 12'hFFF, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("sub111_flags", 32'(bus.flags), 32'b0110);
        chk("sub111_result", 32'(bus.result), 32'hFFF);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // XOR zero result; AND with carry asserted must still give C=0
        drive(3'b010, 12'h5A5, 12'h5A5, 12'h000, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("xor_flags", 32'(bus.flags), 32'b1000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        drive(3'b000, 12'hF0F, 12'h0FF, 12'h00F, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("and_flags", 32'(bus.flags), 32'b0000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("cnt_5", 32'(bus.res_cnt), 32'd5);

        // Back-pressure: three pushes with consumer stalled
        drive(3'b001, 12'h001, 12'h002, 12'h003, 1'b0);
        #1;
        chk("bp_rdy0", 32'(bus.in_ready), 32'h1);
        tick();
        drive(3'b011, 12'h100, 12'h200, 12'h300, 1'b0);
        chk("bp_rdy1", 32'(bus.in_ready), 32'h1);
        tick();
        drive(3'b011, 12'hFFF, 12'h001, 12'h000, 1'b1);
        chk("bp_rdy2", 32'(bus.in_ready), 32'h0);
        tick();
        chk("bp_held_rdy", 32'(bus.in_ready), 32'h0);
        chk("bp_head", 32'(bus.result), 32'h003);
        chk("bp_cnt_hold", 32'(bus.res_cnt), 32'd5);
        bus.out_ready = 1'b1;
        tick();
        chk("drain1_result", 32'(bus.result), 32'h300);
        chk("drain1_cnt", 32'(bus.res_cnt), 32'd6);
        chk("drain1_rdy", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("drain2_result", 32'(bus.result), 32'h000);
        chk("drain2_flags", 32'(bus.flags), 32'b1010);
        chk("drain2_cnt", 32'(bus.res_cnt), 32'd7);
        chk("drain2_valid", 32'(bus.out_valid), 32'h1);
        tick();
        chk("drain3_cnt", 32'(bus.res_cnt), 32'd8);
        chk("drain3_empty", 32'(bus.out_valid), 32'h0);

        // Sticky: clear, V=0 accept keeps it clear, clear+set -> set
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        chk("sticky_clr", 32'(bus.sticky_v), 32'h0);
        drive(3'b100, 12'h000, 12'h001, 12'hFFF, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("sticky_v0", 32'(bus.sticky_v), 32'h0);
        drive(3'b011, 12'h7FF, 12'h001, 12'h800, 1'b0);
        bus.clr_sticky = 1'b1;
        tick();
        bus.in_valid   = 1'b0;
        bus.clr_sticky = 1'b0;
        chk("sticky_set_wins", 32'(bus.sticky_v), 32'h1);
        tick();
        chk("sticky_cnt", 32'(bus.res_cnt), 32'd10);

        // Reset with two entries buffered; input offered during reset
        bus.out_ready = 1'b0;
        drive(3'b001, 12'h000, 12'h000, 12'h111, 1'b0);
        tick();
        drive(3'b001, 12'h000, 12'h000, 12'h222, 1'b0);
        tick();
        chk("full_rdy", 32'(bus.in_ready), 32'h0);
        drive(3'b001, 12'h000, 12'h000, 12'h333, 1'b0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_cnt", 32'(bus.res_cnt), 32'h0);
        chk("mid_rst_result", 32'(bus.result), 32'h0);
        chk("mid_rst_sticky", 32'(bus.sticky_v), 32'h0);
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 32'h0);

        // Full-rate stream of 256 results; counter wraps to 0
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(3'b001, 12'(i), 12'h000, 12'(i), 1'b0);
            tick();
            if (bus.result !== 12'(i) || bus.out_valid !== 1'b1)
                chk("stream_result", {19'(bus.out_valid), 1'b0, bus.result}, {19'd1, 1'b0, 12'(i)});
            else
                nchk++;
        end
        bus.in_valid = 1'b0;
        chk("cnt_255", 32'(bus.res_cnt), 32'd255);
        tick();
        chk("cnt_wrap", 32'(bus.res_cnt), 32'd0);
        chk("stream_empty", 32'(bus.out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/alu12_result_stage.md
# alu12_result_stage

Registered result stage directly downstream of the 12-bit combinational ALU. Captures the ALU result, carry and operation tag under a valid/ready handshake and derives Z/N/C/V flags. Buffers up to two results in a skid buffer so the ALU side never stalls on a one-cycle consumer hiccup. Also keeps a sticky overflow bit and a wrapping count of delivered results.

## Interface
- W, 12, ALU data width; flag logic and result bus scale with it.
- CNT_W, 8, width of the delivered-result counter.
- CLK  in  1  rising-edge clock; sole clock.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  ALU result presented this cycle.
- IN_READY  out  1  stage can accept; low while RST is high.
- SEL  in  3  operation tag:
  - 000 AND, 001 OR, 010 XOR, 011 ADD.
  - 100–111 SUB.
- A  in  W  operand A as fed to the ALU; sign bit used for V.
- B  in  W  operand B as fed to the ALU; sign bit used for V.
- O  in  W+1  ALU result bus; bit W is always 0 and is ignored.
- CARRY  in  1  ALU carry-out for ADD, borrow for SUB, 0 for logic ops.
- OUT_VALID  out  1  head result available.
- OUT_READY  in  1  consumer accepts head result.
- RESULT  out  W  head result (O[W-1:0]).
- FLAGS  out  4  head flags {Z,N,C,V}.
- STICKY_V  out  1  set once any accepted result had V=1.
- CLR_STICKY  in  1  clears STICKY_V.
- RES_CNT  out  CNT_W  number of output handshakes, modulo 2^CNT_W.

## Operation
- Accept on IN_VALID & IN_READY: push {O[W-1:0], flags} into the 2-entry buffer.
- Flags are computed from the inputs at the accept cycle:
  - Z = (O[W-1:0] == 0).
  - N = O[W-1].
  - C = CARRY for ADD and SUB, 0 for logic ops.
  - V for ADD = (A[W-1]==B[W-1]) & (O[W-1]!=A[W-1]).
  - V for SUB = (A[W-1]!=B[W-1]) & (O[W-1]!=A[W-1]).
  - V = 0 for logic ops.
- Pop on OUT_VALID & OUT_READY. RESULT/FLAGS then show the next entry, or hold their last value when empty.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Occupancy 0..2:
  - Push only: +1. Pop only: −1.
  - Push and pop together at occupancy 1: stays 1, and the new entry becomes head next cycle.
  - Push at occupancy 2 cannot happen because IN_READY=0.
- STICKY_V: set on an accept with V=1; cleared by CLR_STICKY. If both happen in the same cycle, set wins.
- RES_CNT: +1 per output handshake; wraps from 2^CNT_W−1 to 0.

## Timing
- Latency is 1 cycle: a result accepted at edge k has OUT_VALID high after edge k (when the buffer was empty).
- Throughput is 1 result/cycle while OUT_READY stays high.
- IN_READY = (occupancy < 2) & ~RST, decoded from registered occupancy. There is no combinational path from OUT_READY to IN_READY.
- OUT_VALID, RESULT and FLAGS are driven directly from registers.
- Reset (synchronous, takes effect at the edge where RST=1):
  - Occupancy=0, OUT_VALID=0, RESULT=0, FLAGS=0, STICKY_V=0, RES_CNT=0.
  - A reset mid-stream discards buffered entries.
  - Inputs sampled during RST are ignored.
- Inputs are sampled only at the accept edge; A/B/SEL/O may change freely afterwards.

## Structure
- Package alu12_pkg holds:
  - W default.
  - SEL encodings as named constants (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB range).
  - Flag bit indices and a packed flags struct {z,n,c,v}.
- Sub-module alu12_flag_gen: purely combinational (SEL, A, B, O, CARRY) → flags. It is reused by any other stage that needs ALU flags.
- Top level contains the 2-entry buffer, occupancy counter, sticky bit and result counter.

## Test plan
- Reset, then a single ADD with A=0x7FF, B=0x001, O=0x800, CARRY=0:
  - OUT_VALID high 1 cycle later.
  - RESULT=0x800, FLAGS Z=0,N=1,C=0,V=1.
  - STICKY_V=1.
- SUB with A=0x000, B=0x001, O=0xFFF, CARRY=1 → FLAGS N=1,C=1,V=0,Z=0. Repeat with SEL=111 and expect identical flags.
- XOR with A=B=0x5A5, O=0x000, CARRY=0 → Z=1, C=0, V=0.
- Back-pressure:
  - Hold OUT_READY=0 and push 3 results.
  - IN_READY drops after the 2nd accept; the 3rd is held off.
  - Release OUT_READY: results drain in order, and RES_CNT increments by 2, then by 3 total.
- Sticky and counter edges:
  - CLR_STICKY in the same cycle as a V=1 accept → STICKY_V stays 1.
  - 256 pops with CNT_W=8 → RES_CNT wraps to 0.
  - RST asserted with 2 entries buffered → next cycle OUT_VALID=0, RES_CNT=0.
